// File: rtl/dbg_pkg.sv
// Shared state encoding and frame constants for the debug register dumper.
package dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEND_PC,
    SEND_INST,
    ADDR,
    LOAD,
    SEND_REG,
    CSUM
  } dbg_state_t;

  localparam logic [7:0] DBG_HEADER = 8'hA5;

  // Header, pc word, inst word, one word per register, checksum byte.
  function automatic int dbg_frame_len(input int num_regs);
    return 1 + 4 + 4 + 4 * num_regs + 1;
  endfunction

endpackage

// File: rtl/dbg_word_serializer.sv
// Emits a loaded 32-bit word as 4 bytes MSB-first under valid/ready; word_done
// marks the handshake of the 4th byte, and a load in that same cycle chains the next word.
module dbg_word_serializer (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        load,
  input  logic [31:0] word,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        word_done
);

  logic [31:0] shreg;
  logic [1:0]  byte_cnt;

  assign data      = shreg[31:24];
  assign word_done = valid && ready && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      shreg    <= 32'd0;
      byte_cnt <= 2'd0;
      valid    <= 1'b0;
    end else if (load) begin
      shreg    <= word;
      byte_cnt <= 2'd0;
      valid    <= 1'b1;
    end else if (valid && ready) begin
      byte_cnt <= byte_cnt + 2'd1;
      // Keep the last byte in place after the word so out_data does not jump to zero.
      if (byte_cnt == 2'd3) begin
        valid <= 1'b0;
      end else begin
        shreg <= {shreg[23:0], 8'h00};
      end
    end
  end

endmodule

// File: rtl/debug_reg_dumper.sv
// Sweeps the core debug register port and streams header, pc, inst, registers and
// an XOR checksum as a valid/ready byte frame; the core must be held during a dump.
module debug_reg_dumper
  import dbg_pkg::*;
#(
  parameter logic [7:0] HEADER   = DBG_HEADER,
  parameter int         NUM_REGS = 32,
  parameter int         SETTLE   = 1
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic [31:0] reg_data_in,
  output logic [4:0]  reg_addr_out,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX    = 5'(NUM_REGS - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  dbg_state_t  state;
  logic [31:0] snap_pc;
  logic [31:0] snap_inst;
  logic [4:0]  idx;
  logic [7:0]  settle_cnt;
  logic [7:0]  checksum;

  logic        ser_load;
  logic [31:0] ser_word;
  logic [7:0]  ser_data;
  logic        ser_valid;
  logic        ser_done;
  logic        xfer;

  dbg_word_serializer u_ser (
    .clk       (clk),
    .aresetn   (aresetn),
    .load      (ser_load),
    .word      (ser_word),
    .data      (ser_data),
    .valid     (ser_valid),
    .ready     (out_ready),
    .word_done (ser_done)
  );

  // Header and checksum bytes come straight from the FSM; all words go through the serializer.
  always_comb begin
    out_valid = ser_valid;
    out_data  = ser_data;
    if (state == HDR) begin
      out_valid = 1'b1;
      out_data  = HEADER;
    end else if (state == CSUM) begin
      out_valid = 1'b1;
      out_data  = checksum;
    end
  end

  assign xfer = out_valid && out_ready;

  always_comb begin
    ser_load = 1'b0;
    ser_word = reg_data_in;
    case (state)
      HDR: begin
        ser_load = out_ready;
        ser_word = snap_pc;
      end
      SEND_PC: begin
        ser_load = ser_done;
        ser_word = snap_inst;
      end
      LOAD:    ser_load = 1'b1;
      default: ser_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state        <= IDLE;
      snap_pc      <= 32'd0;
      snap_inst    <= 32'd0;
      idx          <= 5'd0;
      settle_cnt   <= 8'd0;
      checksum     <= 8'd0;
      reg_addr_out <= 5'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (xfer && (state != HDR) && (state != CSUM)) begin
        checksum <= checksum ^ out_data;
      end
      case (state)
        IDLE: begin
          if (start) begin
            snap_pc      <= pc_in;
            snap_inst    <= inst_in;
            busy         <= 1'b1;
            checksum     <= 8'd0;
            idx          <= 5'd0;
            reg_addr_out <= 5'd0;
            state        <= HDR;
          end
        end
        HDR: begin
          if (out_ready) state <= SEND_PC;
        end
        SEND_PC: begin
          if (ser_done) state <= SEND_INST;
        end
        SEND_INST: begin
          if (ser_done) begin
            reg_addr_out <= idx;
            settle_cnt   <= 8'd0;
            state        <= ADDR;
          end
        end
        ADDR: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= LOAD;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        LOAD: state <= SEND_REG;
        SEND_REG: begin
          if (ser_done) begin
            if (idx == LAST_IDX) begin
              state <= CSUM;
            end else begin
              idx          <= idx + 5'd1;
              reg_addr_out <= idx + 5'd1;
              settle_cnt   <= 8'd0;
              state        <= ADDR;
            end
          end
        end
        CSUM: begin
          if (out_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/debug_reg_dumper.md
Name: debug_reg_dumper

Overview:
- Reader on the core's debug register port: sweeps debug_reg_addr over the register file, samples the returned data plus the current PC and instruction, and serializes them as a byte frame.
- Output is a valid/ready byte stream intended for a UART transmitter or host bridge.
- Sits beside the core at top level.
- The core must be held (step static) during a dump for a coherent register snapshot.

Parameters:
- HEADER, 8'hA5, first byte of every frame
- NUM_REGS, 32, registers dumped (addresses 0..NUM_REGS-1; max 32)
- SETTLE, 1, cycles between driving reg_addr_out and sampling reg_data_in (>=1)

Ports:
- clk  in  1  system clock
- aresetn  in  1  synchronous active-low reset
- start  in  1  single-cycle request to begin a frame
- pc_in  in  32  current PC from the core debug output
- inst_in  in  32  current instruction from the core debug output
- reg_data_in  in  32  register data for reg_addr_out
- reg_addr_out  out  5  debug register address to core
- out_data  out  8  stream byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts byte
- busy  out  1  high from start acceptance until frame end
- done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset: the one clock is clk; reset is synchronous and active-low on aresetn. On the clk edge with aresetn=0: state=IDLE, reg_addr_out=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0, all counters=0. Reset mid-frame aborts immediately; no partial byte is held.
- Frame format, 1+4+4+4*NUM_REGS+1 bytes (138 at default):
  - HEADER
  - pc (MSB first)
  - inst (MSB first)
  - reg0..reg(NUM_REGS-1), each MSB first
  - checksum = XOR of all bytes after the header
- States and transitions:
  - IDLE: start=1 -> latch pc_in and inst_in into the snapshot register, busy<=1, checksum<=0 -> HDR.
  - HDR: present HEADER -> on handshake -> SEND_PC.
  - SEND_PC, SEND_INST: present 4 bytes of the snapshot word each.
  - ADDR: drive reg_addr_out=idx; wait SETTLE cycles -> LOAD.
  - LOAD: capture reg_data_in into the word register -> SEND_REG.
  - SEND_REG: present 4 bytes; after the 4th handshake, idx==NUM_REGS-1 -> CSUM, else idx+1 -> ADDR.
  - CSUM: present checksum -> on handshake -> IDLE with busy<=0 and done=1 for one cycle.
- Handshake:
  - A byte transfers on the clk edge where out_valid&&out_ready.
  - While out_valid=1 and out_ready=0, out_data is held stable and out_valid is not deasserted.
  - The next byte may be presented the cycle after a transfer; throughput is 1 byte/cycle within a word when out_ready is held high.
  - out_valid=0 during ADDR/LOAD. Per-register bubble: SETTLE+1 cycles.
- Checksum updates on each non-header transfer: checksum ^= out_data.
- Byte counter is 2 bits; it wraps 3->0 on word completion.
- idx is 5 bits; no wrap is reachable since it terminates at NUM_REGS-1.
- start while busy is ignored (not queued). start in the same cycle as the final CSUM handshake is also ignored.
- reg_addr_out holds its last value between states and returns to 0 only on reset or a new start.
- pc/inst are snapshotted at start acceptance; later changes on pc_in/inst_in do not affect the frame.

Decomposition:
- Shared package dbg_pkg:
  - state enum (IDLE, HDR, SEND_PC, SEND_INST, ADDR, LOAD, SEND_REG, CSUM)
  - DBG_HEADER constant
  - frame-length constant function of NUM_REGS
- One natural sub-module, dbg_word_serializer: loads a 32-bit word, emits 4 bytes MSB-first under valid/ready, and pulses word_done. The top FSM reuses it for pc, inst and registers.

Test Plan:
- Reset and idle: aresetn=0 for 2 cycles, then 1 with no start -> out_valid=0, busy=0, reg_addr_out=0 persist for 20 cycles.
- Basic frame: pc_in=32'h0000_0010, inst_in=32'h0010_0093, reg model returns 32'h1000_0000+addr, out_ready=1, pulse start ->
  - 138 bytes received
  - bytes 1-8: 00 00 00 10 00 10 00 93
  - reg31 bytes: 10 00 00 1F
  - checksum matches the bench XOR
  - done pulses exactly once; busy falls the same cycle
- Backpressure: out_ready toggled randomly, held low for 7 cycles on byte 5 -> out_data stays 8'h00 and valid stays high throughout; the frame is byte-identical to the basic case.
- Snapshot and ignored start: change pc_in to 32'hDEAD_BEEF and pulse start mid-frame -> frame still carries pc 00000010; no second frame starts.
- Reset mid-frame: drop aresetn during reg 12 -> next cycle out_valid=0, busy=0; a fresh start then yields a complete, correct 138-byte frame.
- SETTLE=3 build: register model with 2-cycle read latency -> all 32 register values correct; gap between reg words is 4 cycles.
